int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 150 +++++++++++++++
 tb/tb_int_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: 8-line edge-triggered interrupt controller with a memory-mapped
// register window for a single CPU.
//
// Optional synchronizer: define INTCTRL_SYNC_EN to put each interrupt line
// through a 2-flop synchronizer before edge detection (+2 cycles latency).
//
// Parameters:
//   BASE_ADDR   word-aligned base byte address of the register window
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   interrupts  external interrupt lines, one request per rising edge
//   memwrite    CPU store strobe
//   dataadr     CPU byte address (read and write)
//   writedata   CPU store data
//   readdata    register read data, combinational from dataadr
//   int_req     interrupt request to the CPU (combinational from registers)
//   int_id      granted source index, lowest index wins; 0 when int_req=0
//   int_ack     one-cycle acknowledge of int_id
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 PENDING[7:0] R/W1C   0x04 MASK[7:0] R/W   0x08 CTRL[0]=GIE R/W
//   0x0C ID={int_req,int_id} RO                    0x10 OVF[7:0] R/W1C
module int_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  interrupts,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        int_req,
    output logic [2:0]  int_id,
    input  logic        int_ack
);

    localparam int unsigned NIRQ = 8;
    localparam int unsigned IDW  = 3;
    localparam int unsigned DW   = 32;

    localparam logic [31:0] OFF_PENDING = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK    = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL    = 32'h0000_0008;
    localparam logic [31:0] OFF_ID      = 32'h0000_000C;
    localparam logic [31:0] OFF_OVF     = 32'h0000_0010;

    logic [NIRQ-1:0] pending_q;
    logic [NIRQ-1:0] mask_q;
    logic [NIRQ-1:0] ovf_q;
    logic            gie_q;
    logic [NIRQ-1:0] prev_q;

    logic [NIRQ-1:0] sampled;
    logic [NIRQ-1:0] edges;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] w1c_clr;
    logic [NIRQ-1:0] pend_clr;
    logic [NIRQ-1:0] ovf_clr;
    logic [IDW-1:0]  id_sel;

    logic sel_pending, sel_mask, sel_ctrl, sel_id, sel_ovf;
    logic unused_wdata;

    // Only the low byte (and bit 0 for CTRL) of store data is ever used.
    assign unused_wdata = ^writedata[DW-1:NIRQ];

    // Input sampling: either the raw lines or a 2-flop synchronizer output.
`ifdef INTCTRL_SYNC_EN
    logic [NIRQ-1:0] sync1_q;
    logic [NIRQ-1:0] sync2_q;

    // Synchronizer preloads with the live line value in reset so no edge
    // is fabricated on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= interrupts;
            sync2_q <= interrupts;
        end else begin
            sync1_q <= interrupts;
            sync2_q <= sync1_q;
        end
    end
    assign sampled = sync2_q;
`else
    assign sampled = interrupts;
`endif

    // Previous-sample register for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) prev_q <= interrupts;
        else       prev_q <= sampled;
    end

    assign edges = sampled & ~prev_q;

    // Address decode: full 32-bit match against the window.
    assign sel_pending = (dataadr == BASE_ADDR + OFF_PENDING);
    assign sel_mask    = (dataadr == BASE_ADDR + OFF_MASK);
    assign sel_ctrl    = (dataadr == BASE_ADDR + OFF_CTRL);
    assign sel_id      = (dataadr == BASE_ADDR + OFF_ID);
    assign sel_ovf     = (dataadr == BASE_ADDR + OFF_OVF);

    // Request and lowest-index priority select.
    assign active  = pending_q & mask_q;
    assign int_req = gie_q & (|active);

    always_comb begin
        id_sel = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (active[i]) id_sel = IDW'(i);
        end
    end

    assign int_id = int_req ? id_sel : '0;

    // Clear sources; an arriving edge overrides them below.
    assign ack_clr  = (int_req && int_ack) ? (NIRQ'(1) << int_id) : '0;
    assign w1c_clr  = (memwrite && sel_pending) ? writedata[NIRQ-1:0] : '0;
    assign pend_clr = ack_clr | w1c_clr;
    assign ovf_clr  = (memwrite && sel_ovf) ? writedata[NIRQ-1:0] : '0;

    // Register state; overflow only when the pending bit survives this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            ovf_q     <= '0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | edges;
            ovf_q     <= (ovf_q & ~ovf_clr) | (edges & pending_q & ~pend_clr);
            if (memwrite && sel_mask) mask_q <= writedata[NIRQ-1:0];
            if (memwrite && sel_ctrl) gie_q  <= writedata[0];
        end
    end

    // Read mux, zero-extended; unmapped addresses read as zero.
    always_comb begin
        readdata = '0;
        if (sel_pending)   readdata = DW'(pending_q);
        else if (sel_mask) readdata = DW'(mask_q);
        else if (sel_ctrl) readdata = DW'(gie_q);
        else if (sel_id)   readdata = DW'({int_req, int_id});
        else if (sel_ovf)  readdata = DW'(ovf_q);
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of single-transaction vectors
// plus hand sequences for reset, ack/edge collision and held-high lines.
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] R_PEND = 32'h00;
    localparam logic [31:0] R_MASK = 32'h04;
    localparam logic [31:0] R_CTRL = 32'h08;
    localparam logic [31:0] R_ID   = 32'h0C;
    localparam logic [31:0] R_OVF  = 32'h10;
    localparam logic [31:0] R_NONE = 32'h14;
`ifdef INTCTRL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  interrupts;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupts (interrupts),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_ack    (int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rd_adr;
        logic        req;
        logic [2:0]  id;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          tag;
        logic        req;
        logic [2:0]  id;
        logic [31:0] rd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic [7:0] irq, input logic wr, input logic [31:0] off,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rd_off,
                       input logic req, input logic [2:0] id, input logic [31:0] rd);
        vec_t v;
        v.irq = irq; v.wr = wr; v.adr = BASE + off; v.wd = wd; v.ack = ack;
        v.rd_adr = BASE + rd_off; v.req = req; v.id = id; v.rd = rd;
        vecs.push_back(v);
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic [7:0] irq, input logic wr, input logic [31:0] adr,
                         input logic [31:0] wd, input logic ack, input logic rst);
        @(posedge clk);
        #1;
        interrupts = irq; memwrite = wr; dataadr = adr;
        writedata = wd; int_ack = ack; reset = rst;
    endtask

    // Push expectation, then compare at the falling edge of the current cycle.
    task automatic check(input int tag, input logic req, input logic [2:0] id,
                         input logic [31:0] rd);
        exp_t e;
        e.tag = tag; e.req = req; e.id = id; e.rd = rd;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (int_req !== e.req) begin
            bad++;
            $display("FAIL int_req tag=%0d got=%0b want=%0b", e.tag, int_req, e.req);
        end
        total++;
        if (int_id !== e.id) begin
            bad++;
            $display("FAIL int_id tag=%0d got=%0d want=%0d", e.tag, int_id, e.id);
        end
        total++;
        if (readdata !== e.rd) begin
            bad++;
            $display("FAIL readdata tag=%0d got=%h want=%h", e.tag, readdata, e.rd);
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        drive(v.irq, v.wr, v.adr, v.wd, v.ack, 1'b0);
        repeat (LAT) drive(8'h00, 1'b0, v.rd_adr, 32'h0, 1'b0, 1'b0);
        check(tag, v.req, v.id, v.rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tag=999 got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; interrupts = 8'h00; memwrite = 1'b0;
        dataadr = BASE; writedata = 32'h0; int_ack = 1'b0;

        //  irq    wr    off     wdata          ack   rd_off  req   id    rd
        add(8'h00, 1'b1, R_MASK, 32'h0000_00FF, 1'b0, R_MASK, 1'b0, 3'd0, 32'hFF);
        add(8'h00, 1'b1, R_CTRL, 32'h0000_0001, 1'b0, R_CTRL, 1'b0, 3'd0, 32'h01);
        add(8'h02, 1'b0, R_ID,   32'h0,         1'b0, R_ID,   1'b1, 3'd1, 32'h09);
        add(8'h00, 1'b0, R_PEND, 32'h0,         1'b1, R_PEND, 1'b0, 3'd0, 32'h00);
        add(8'h03, 1'b0, R_ID,   32'h0,         1'b0, R_ID,   1'b1, 3'd0, 32'h08);
        add(8'h00, 1'b0, R_ID,   32'h0,         1'b1, R_ID,   1'b1, 3'd1, 32'h09);
        add(8'h00, 1'b0, R_PEND, 32'h0,         1'b1, R_PEND, 1'b0, 3'd0, 32'h00);
        add(8'h02, 1'b0, R_PEND, 32'h0,         1'b0, R_PEND, 1'b1, 3'd1, 32'h02);
        add(8'h02, 1'b0, R_OVF,  32'h0,         1'b0, R_OVF,  1'b1, 3'd1, 32'h02);
        add(8'h00, 1'b1, R_OVF,  32'h0000_0002, 1'b0, R_OVF,  1'b1, 3'd1, 32'h00);
        add(8'h00, 1'b1, R_PEND, 32'h0000_0002, 1'b0, R_PEND, 1'b0, 3'd0, 32'h00);
        add(8'h00, 1'b1, R_MASK, 32'h0000_0000, 1'b0, R_MASK, 1'b0, 3'd0, 32'h00);
        add(8'h08, 1'b0, R_PEND, 32'h0,         1'b0, R_PEND, 1'b0, 3'd0, 32'h08);
        add(8'h00, 1'b1, R_MASK, 32'h0000_0008, 1'b0, R_ID,   1'b1, 3'd3, 32'h0B);
        add(8'h00, 1'b1, R_CTRL, 32'h0000_0000, 1'b0, R_ID,   1'b0, 3'd0, 32'h00);
        add(8'h00, 1'b1, R_CTRL, 32'h0000_0001, 1'b0, R_CTRL, 1'b1, 3'd3, 32'h01);
        add(8'h80, 1'b0, R_PEND, 32'h0,         1'b0, R_PEND, 1'b1, 3'd3, 32'h88);
        add(8'h00, 1'b1, R_MASK, 32'h0000_00FF, 1'b0, R_ID,   1'b1, 3'd3, 32'h0B);
        add(8'h01, 1'b0, R_ID,   32'h0,         1'b0, R_ID,   1'b1, 3'd0, 32'h08);
        add(8'h00, 1'b1, R_NONE, 32'hFFFF_FFFF, 1'b0, R_NONE, 1'b1, 3'd0, 32'h00);
        add(8'h00, 1'b1, R_ID,   32'h0000_0000, 1'b0, R_ID,   1'b1, 3'd0, 32'h08);
        add(8'h00, 1'b1, R_PEND, 32'h0000_00FF, 1'b0, R_PEND, 1'b0, 3'd0, 32'h00);
        add(8'h00, 1'b0, R_OVF,  32'h0,         1'b0, R_OVF,  1'b0, 3'd0, 32'h00);
        add(8'h00, 1'b1, R_MASK, 32'hFFFF_FF01, 1'b0, R_MASK, 1'b0, 3'd0, 32'h01);
        add(8'h00, 1'b1, R_MASK, 32'h0000_00FF, 1'b0, R_MASK, 1'b0, 3'd0, 32'hFF);
        add(8'h04, 1'b0, R_ID,   32'h0,         1'b0, R_ID,   1'b1, 3'd2, 32'h0A);

        // Reset state, checked while reset is held and just after release.
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b1);
        check(1, 1'b0, 3'd0, 32'h00);
        drive(8'h00, 1'b0, BASE + R_MASK, 32'h0, 1'b0, 1'b1);
        check(2, 1'b0, 3'd0, 32'h00);
        drive(8'h00, 1'b0, BASE + R_CTRL, 32'h0, 1'b0, 1'b0);
        check(3, 1'b0, 3'd0, 32'h00);

        foreach (vecs[i]) run_vec(vecs[i], 10 + i);

        // Ack of line 2 in the same cycle its next edge is detected.
        for (int k = 0; k < LAT; k++)
            drive((k == 0) ? 8'h04 : 8'h00, 1'b0, BASE + R_PEND, 32'h0,
                  (k == LAT - 1), 1'b0);
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        check(200, 1'b1, 3'd2, 32'h04);
        drive(8'h00, 1'b0, BASE + R_OVF, 32'h0, 1'b0, 1'b0);
        check(201, 1'b1, 3'd2, 32'h00);
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b1, 1'b0);
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        check(202, 1'b0, 3'd0, 32'h00);

        // Line 0 held high through reset release: no edge until it re-rises.
        repeat (3) drive(8'h01, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < LAT + 2; k++)
            drive(8'h01, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        check(300, 1'b0, 3'd0, 32'h00);
        drive(8'h00, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        drive(8'h01, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        repeat (LAT) drive(8'h01, 1'b0, BASE + R_PEND, 32'h0, 1'b0, 1'b0);
        check(301, 1'b0, 3'd0, 32'h01);
        drive(8'h01, 1'b1, BASE + R_MASK, 32'h0000_0001, 1'b0, 1'b0);
        drive(8'h01, 1'b1, BASE + R_CTRL, 32'h0000_0001, 1'b0, 1'b0);
        drive(8'h01, 1'b0, BASE + R_ID, 32'h0, 1'b0, 1'b0);
        check(302, 1'b1, 3'd0, 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
